// File: rtl/crc32_pkg.sv
// Shared CRC-32 definitions for the word-parallel receive checker and transmit generator.
// Latency: n/a (constants, types and a pure combinational helper function).
// Backpressure: n/a.
package crc32_pkg;

   localparam logic [31:0] CRC_POLY       = 32'h04C1_1DB7;
   localparam logic [31:0] INIT_DEFAULT   = 32'hFFFF_FFFF;
   localparam logic [31:0] XOROUT_DEFAULT = 32'h0000_0000;

   // IDLE: hold register empty; HOLD: hold register carries a payload candidate
   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } rx_state_e;

   // One 32-bit step, MSB first, no reflection: fold the word into the state,
   // then clock the zero-input register 32 times.
   function automatic logic [31:0] crc32_word_step(input logic [31:0] state,
                                                   input logic [31:0] word);
      logic [31:0] v;
      v = state ^ word;
      for (int i = 0; i < 32; i++) begin
         v = v[31] ? ((v << 1) ^ CRC_POLY) : (v << 1);
      end
      return v;
   endfunction

endpackage

// File: rtl/crc32_word_step_comb.sv
// Combinational CRC-32 word step: next_o = W(state_i ^ word_i).
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: state_i current CRC register, word_i 32-bit data word (bit 31 first),
//        next_o CRC register after absorbing the word.
module crc32_word_step_comb
   import crc32_pkg::*;
(
   input  logic [31:0] state_i,
   input  logic [31:0] word_i,
   output logic [31:0] next_o
);

   always_comb begin
      next_o = crc32_word_step(state_i, word_i);
   end

endmodule

// File: rtl/crc32_rx_checker.sv
// Receive CRC-32 checker: forwards payload with FCS stripped, reports per-frame CRC/length status.
// Latency: a payload word leaves one cycle after the following input word is accepted; status one cycle after FCS.
// Backpressure: s_ready = !m_valid | m_ready, combinational through a single output register.
// Ports: clk/rst (sync, active-high); s_* input word stream, s_last marks the FCS word;
//        m_* payload stream; st_* registered per-frame status (st_valid pulses once per frame);
//        err_cnt saturating count of bad frames.
module crc32_rx_checker
   import crc32_pkg::*;
#(
   parameter logic [31:0] INIT      = INIT_DEFAULT,
   parameter logic [31:0] XOROUT    = XOROUT_DEFAULT,
   parameter int unsigned MAX_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [31:0] s_data,
   input  logic        s_last,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [31:0] m_data,
   output logic        m_last,
   output logic        st_valid,
   output logic        st_crc_ok,
   output logic        st_len_err,
   output logic [31:0] st_crc,
   output logic [15:0] st_words,
   output logic [15:0] err_cnt
);

   localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

   rx_state_e   state_q, state_d;
   logic [31:0] hold_q, hold_d;
   logic [31:0] crc_q, crc_d;
   logic [15:0] cnt_q, cnt_d;
   logic        m_valid_q, m_valid_d;
   logic [31:0] m_data_q, m_data_d;
   logic        m_last_q, m_last_d;
   logic        st_valid_q, st_valid_d;
   logic        st_crc_ok_q, st_crc_ok_d;
   logic        st_len_err_q, st_len_err_d;
   logic [31:0] st_crc_q, st_crc_d;
   logic [15:0] st_words_q, st_words_d;
   logic [15:0] err_cnt_q, err_cnt_d;

   logic [31:0] step_crc;
   logic        accept;
   logic [15:0] words_inc;
   logic        frame_end;
   logic [15:0] frame_words;
   logic [31:0] frame_crc;
   logic        frame_ok;
   logic        frame_len_err;

   // CRC of everything pushed so far plus the word currently held
   crc32_word_step_comb u_step (
      .state_i (crc_q),
      .word_i  (hold_q),
      .next_o  (step_crc)
   );

   assign s_ready = !m_valid_q || m_ready;
   assign accept  = s_valid && s_ready;

   always_comb begin
      state_d       = state_q;
      hold_d        = hold_q;
      crc_d         = crc_q;
      cnt_d         = cnt_q;
      m_valid_d     = m_valid_q;
      m_data_d      = m_data_q;
      m_last_d      = m_last_q;
      st_valid_d    = 1'b0;
      st_crc_ok_d   = st_crc_ok_q;
      st_len_err_d  = st_len_err_q;
      st_crc_d      = st_crc_q;
      st_words_d    = st_words_q;
      err_cnt_d     = err_cnt_q;
      words_inc     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
      frame_end     = 1'b0;
      frame_words   = 16'd0;
      frame_crc     = INIT ^ XOROUT;
      frame_ok      = 1'b0;
      frame_len_err = 1'b0;

      if (m_valid_q && m_ready) begin
         m_valid_d = 1'b0;
      end

      if (accept) begin
         if (state_q == IDLE) begin
            if (s_last) begin
               // FCS with nothing held: zero-length frame, CRC never stepped
               frame_end = 1'b1;
            end else begin
               hold_d  = s_data;
               state_d = HOLD;
            end
         end else begin
            // A new word proves the held one is payload; it moves to the output
            m_valid_d = 1'b1;
            m_data_d  = hold_q;
            m_last_d  = s_last;
            if (s_last) begin
               frame_end   = 1'b1;
               frame_words = words_inc;
               frame_crc   = step_crc ^ XOROUT;
               crc_d       = INIT;
               cnt_d       = 16'd0;
               state_d     = IDLE;
            end else begin
               crc_d  = step_crc;
               cnt_d  = words_inc;
               hold_d = s_data;
            end
         end
      end

      if (frame_end) begin
         frame_ok      = (frame_crc == s_data);
         frame_len_err = (frame_words == 16'd0) || ({1'b0, frame_words} > MAX_W);
         st_valid_d    = 1'b1;
         st_crc_ok_d   = frame_ok;
         st_len_err_d  = frame_len_err;
         st_crc_d      = frame_crc;
         st_words_d    = frame_words;
         if ((!frame_ok || frame_len_err) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         hold_q       <= 32'd0;
         crc_q        <= INIT;
         cnt_q        <= 16'd0;
         m_valid_q    <= 1'b0;
         m_data_q     <= 32'd0;
         m_last_q     <= 1'b0;
         st_valid_q   <= 1'b0;
         st_crc_ok_q  <= 1'b0;
         st_len_err_q <= 1'b0;
         st_crc_q     <= 32'd0;
         st_words_q   <= 16'd0;
         err_cnt_q    <= 16'd0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         crc_q        <= crc_d;
         cnt_q        <= cnt_d;
         m_valid_q    <= m_valid_d;
         m_data_q     <= m_data_d;
         m_last_q     <= m_last_d;
         st_valid_q   <= st_valid_d;
         st_crc_ok_q  <= st_crc_ok_d;
         st_len_err_q <= st_len_err_d;
         st_crc_q     <= st_crc_d;
         st_words_q   <= st_words_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign m_valid    = m_valid_q;
   assign m_data     = m_data_q;
   assign m_last     = m_last_q;
   assign st_valid   = st_valid_q;
   assign st_crc_ok  = st_crc_ok_q;
   assign st_len_err = st_len_err_q;
   assign st_crc     = st_crc_q;
   assign st_words   = st_words_q;
   assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_crc32_rx_checker.sv
// Bench for crc32_rx_checker: two instances share one input stream,
// dut_a with INIT=0/MAX_WORDS=4 and dut_b with default parameters.
// Handshake-level behaviour is identical in both, so one s_ready drives the stimulus.
module tb_crc32_rx_checker;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_valid;
   logic [31:0] s_data;
   logic        s_last;
   logic        m_ready;

   logic        s_ready_a, m_valid_a, m_last_a, st_valid_a, st_crc_ok_a, st_len_err_a;
   logic [31:0] m_data_a, st_crc_a;
   logic [15:0] st_words_a, err_cnt_a;
   logic        s_ready_b, m_valid_b, m_last_b, st_valid_b, st_crc_ok_b, st_len_err_b;
   logic [31:0] m_data_b, st_crc_b;
   logic [15:0] st_words_b, err_cnt_b;

   int n_tests = 0;
   int n_fail  = 0;
   bit rand_mode = 1'b0;

   logic [32:0] out_q[$];
   logic [32:0] exp_q[$];
   int st_cnt, st_ok_cnt, st_len_cnt;

   always #5 clk = ~clk;

   crc32_rx_checker #(.INIT(32'h0000_0000), .XOROUT(32'h0000_0000), .MAX_WORDS(4)) dut_a (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_a), .s_data(s_data),
      .s_last(s_last), .m_valid(m_valid_a), .m_ready(m_ready), .m_data(m_data_a),
      .m_last(m_last_a), .st_valid(st_valid_a), .st_crc_ok(st_crc_ok_a),
      .st_len_err(st_len_err_a), .st_crc(st_crc_a), .st_words(st_words_a), .err_cnt(err_cnt_a)
   );

   crc32_rx_checker dut_b (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data),
      .s_last(s_last), .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b),
      .m_last(m_last_b), .st_valid(st_valid_b), .st_crc_ok(st_crc_ok_b),
      .st_len_err(st_len_err_b), .st_crc(st_crc_b), .st_words(st_words_b), .err_cnt(err_cnt_b)
   );

   // Bit-serial reference: feedback = msb ^ data bit, data taken MSB first
   function automatic logic [31:0] crc_ser(input logic [31:0] c, input logic [31:0] w);
      logic fb;
      for (int b = 31; b >= 0; b--) begin
         fb = c[31] ^ w[b];
         c  = {c[30:0], 1'b0};
         if (fb) c = c ^ 32'h04C1_1DB7;
      end
      return c;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: record dut_b handshakes of the current cycle, advance, then
   // optionally re-randomise m_ready well clear of the edge.
   task automatic cyc();
      if (m_valid_b === 1'b1 && m_ready) out_q.push_back({m_last_b, m_data_b});
      if (st_valid_b === 1'b1) begin
         st_cnt++;
         if (st_crc_ok_b)  st_ok_cnt++;
         if (st_len_err_b) st_len_cnt++;
      end
      @(posedge clk);
      #1;
      if (rand_mode) m_ready = 1'($urandom_range(0, 1));
      #1;
   endtask

   task automatic send(input logic [31:0] d, input logic l);
      int waits;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      waits   = 0;
      while (s_ready_b !== 1'b1 && waits < 200) begin
         cyc();
         waits++;
      end
      if (waits >= 200) begin
         chk("send_timeout", 32'(waits), 32'd0);
      end else begin
         cyc();
      end
      s_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      logic [31:0] p[5];
      logic [31:0] c;
      int len, nmis;

      rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
      cyc();
      cyc();

      // Reset values
      chk("rst_s_ready",   32'(s_ready_a),    32'd1);
      chk("rst_m_valid",   32'(m_valid_a),    32'd0);
      chk("rst_m_last",    32'(m_last_a),     32'd0);
      chk("rst_m_data",    m_data_a,          32'd0);
      chk("rst_st_valid",  32'(st_valid_a),   32'd0);
      chk("rst_st_ok",     32'(st_crc_ok_a),  32'd0);
      chk("rst_st_len",    32'(st_len_err_a), 32'd0);
      chk("rst_st_crc",    st_crc_a,          32'd0);
      chk("rst_st_words",  32'(st_words_a),   32'd0);
      chk("rst_err_cnt",   32'(err_cnt_b),    32'd0);
      rst = 1'b0;

      // INIT=0: single word 1 gives CRC equal to the polynomial
      send(32'h0000_0001, 1'b0);
      chk("a_held_not_out", 32'(m_valid_a), 32'd0);
      send(32'h04C1_1DB7, 1'b1);
      chk("a1_m_valid",  32'(m_valid_a),    32'd1);
      chk("a1_m_data",   m_data_a,          32'h0000_0001);
      chk("a1_m_last",   32'(m_last_a),     32'd1);
      chk("a1_st_valid", 32'(st_valid_a),   32'd1);
      chk("a1_st_crc",   st_crc_a,          32'h04C1_1DB7);
      chk("a1_st_ok",    32'(st_crc_ok_a),  32'd1);
      chk("a1_st_words", 32'(st_words_a),   32'd1);
      chk("a1_st_len",   32'(st_len_err_a), 32'd0);
      cyc();
      chk("a1_st_pulse", 32'(st_valid_a),   32'd0);
      chk("a1_st_hold",  st_crc_a,          32'h04C1_1DB7);
      chk("a1_drained",  32'(m_valid_a),    32'd0);

      // Default INIT: 0xFFFFFFFF cancels INIT, CRC is zero
      do_reset();
      send(32'hFFFF_FFFF, 1'b0);
      send(32'h0000_0000, 1'b1);
      chk("b_ok_crc",   st_crc_b,          32'd0);
      chk("b_ok_flag",  32'(st_crc_ok_b),  32'd1);
      chk("b_ok_err",   32'(err_cnt_b),    32'd0);
      send(32'hFFFF_FFFF, 1'b0);
      send(32'h0000_0001, 1'b1);
      chk("b_bad_flag", 32'(st_crc_ok_b),  32'd0);
      chk("b_bad_err",  32'(err_cnt_b),    32'd1);

      // Zero-length frame: FCS only
      send(32'h1234_5678, 1'b1);
      chk("z_st_valid", 32'(st_valid_b),   32'd1);
      chk("z_m_valid",  32'(m_valid_b),    32'd0);
      chk("z_len_err",  32'(st_len_err_b), 32'd1);
      chk("z_st_crc_b", st_crc_b,          32'hFFFF_FFFF);
      chk("z_st_crc_a", st_crc_a,          32'h0000_0000);
      chk("z_words",    32'(st_words_b),   32'd0);
      chk("z_err_cnt",  32'(err_cnt_b),    32'd2);

      // Oversize frame on dut_a (MAX_WORDS=4): 5 words, forwarded in full
      do_reset();
      c = 32'h0;
      for (int i = 0; i < 5; i++) begin
         p[i] = 32'h1111_1111 * 32'(i + 1);
         c = crc_ser(c, p[i]);
      end
      for (int i = 0; i < 5; i++) begin
         send(p[i], 1'b0);
         if (i > 0) begin
            chk($sformatf("big_m_data%0d", i - 1), m_data_a, p[i - 1]);
            chk($sformatf("big_m_last%0d", i - 1), 32'(m_last_a), 32'd0);
         end
      end
      send(c, 1'b1);
      chk("big_m_data4",  m_data_a,          p[4]);
      chk("big_m_last4",  32'(m_last_a),     32'd1);
      chk("big_ok_a",     32'(st_crc_ok_a),  32'd1);
      chk("big_len_a",    32'(st_len_err_a), 32'd1);
      chk("big_words_a",  32'(st_words_a),   32'd5);
      chk("big_len_b",    32'(st_len_err_b), 32'd0);
      chk("big_err_a",    32'(err_cnt_a),    32'd1);

      // 100 back-to-back random frames against dut_b with random m_ready
      do_reset();
      out_q.delete(); exp_q.delete();
      st_cnt = 0; st_ok_cnt = 0; st_len_cnt = 0;
      rand_mode = 1'b1;
      for (int f = 0; f < 100; f++) begin
         len = $urandom_range(1, 6);
         c = 32'hFFFF_FFFF;
         for (int i = 0; i < len; i++) begin
            logic [31:0] w;
            w = $urandom();
            c = crc_ser(c, w);
            exp_q.push_back({(i == len - 1), w});
            send(w, 1'b0);
         end
         send(c, 1'b1);
      end
      for (int k = 0; k < 400 && out_q.size() < exp_q.size(); k++) cyc();
      rand_mode = 1'b0;
      m_ready = 1'b1;
      for (int k = 0; k < 4; k++) cyc();
      nmis = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i >= out_q.size() || out_q[i] !== exp_q[i]) nmis++;
      end
      chk("rnd_out_count",  32'(out_q.size()), 32'(exp_q.size()));
      chk("rnd_mismatches", 32'(nmis),         32'd0);
      chk("rnd_st_count",   32'(st_cnt),       32'd100);
      chk("rnd_st_ok",      32'(st_ok_cnt),    32'd100);
      chk("rnd_st_len",     32'(st_len_cnt),   32'd0);
      chk("rnd_err_cnt",    32'(err_cnt_b),    32'd0);

      // Reset after 3 of 6 payload words, then a clean frame
      send(32'hDEAD_0001, 1'b0);
      send(32'hDEAD_0002, 1'b0);
      send(32'hDEAD_0003, 1'b0);
      send(32'hBAD0_0000, 1'b1);   // leaves error state in counters
      send(32'hA5A5_0001, 1'b0);
      send(32'hA5A5_0002, 1'b0);
      send(32'hA5A5_0003, 1'b0);
      chk("mid_pre_m_data", m_data_b, 32'hA5A5_0002);
      do_reset();
      chk("mid_s_ready",  32'(s_ready_b),    32'd1);
      chk("mid_m_valid",  32'(m_valid_b),    32'd0);
      chk("mid_m_data",   m_data_b,          32'd0);
      chk("mid_m_last",   32'(m_last_b),     32'd0);
      chk("mid_st_valid", 32'(st_valid_b),   32'd0);
      chk("mid_st_crc",   st_crc_b,          32'd0);
      chk("mid_st_words", 32'(st_words_b),   32'd0);
      chk("mid_err_cnt",  32'(err_cnt_b),    32'd0);
      c = crc_ser(crc_ser(32'hFFFF_FFFF, 32'h0BAD_CAFE), 32'h1357_9BDF);
      send(32'h0BAD_CAFE, 1'b0);
      send(32'h1357_9BDF, 1'b0);
      send(c, 1'b1);
      chk("post_ok",    32'(st_crc_ok_b), 32'd1);
      chk("post_crc",   st_crc_b,         c);
      chk("post_words", 32'(st_words_b),  32'd2);
      chk("post_last",  32'(m_last_b),    32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
